// File: rtl/flex_timer.sv
// ---------------------------------------------------------------------------
// flex_timer
//   PWM timebase: a prescaled counter that runs up, down, up-down
//   (centre-aligned) or as a one-shot up counter. Period and compare values
//   are double-buffered through shadow registers. The shadows reload on
//   clear and on every update event, so mid-period writes only take effect
//   at the next period boundary.
//
// Parameters
//   NUM_CNT_BITS   width of counter, period and each compare value
//   NUM_CMP        number of compare channels
//   PRESCALE_BITS  width of prescaler divide value
//
// Ports
//   i_clk            system clock, rising edge
//   i_rst_n          asynchronous active-low reset
//   i_clear          synchronous restart: count/prescaler to 0, load shadows
//   i_count_enable   enables prescaler and counter
//   i_mode           00 up, 01 down, 10 up-down, 11 one-shot up
//   i_period         terminal value P (count range 0..P)
//   i_prescale       counter ticks every i_prescale+1 enabled cycles
//   i_cmp_val        compare values, channel i at [i*NUM_CNT_BITS +: NUM_CNT_BITS]
//   o_count_out      current count (registered)
//   o_dir            0 counting up, 1 counting down (up-down mode only)
//   o_rollover_flag  one-cycle pulse in the cycle the post-update count shows
//   o_cmp_match      channel i high while o_count_out < compare shadow i
//   o_done           one-shot finished, counter halted until clear
// ---------------------------------------------------------------------------
module flex_timer #(
  parameter int NUM_CNT_BITS  = 8,
  parameter int NUM_CMP       = 2,
  parameter int PRESCALE_BITS = 4
) (
  input  logic                            i_clk,
  input  logic                            i_rst_n,
  input  logic                            i_clear,
  input  logic                            i_count_enable,
  input  logic [1:0]                      i_mode,
  input  logic [NUM_CNT_BITS-1:0]         i_period,
  input  logic [PRESCALE_BITS-1:0]        i_prescale,
  input  logic [NUM_CMP*NUM_CNT_BITS-1:0] i_cmp_val,
  output logic [NUM_CNT_BITS-1:0]         o_count_out,
  output logic                            o_dir,
  output logic                            o_rollover_flag,
  output logic [NUM_CMP-1:0]              o_cmp_match,
  output logic                            o_done
);

  typedef enum logic [1:0] {
    MODE_UP      = 2'b00,
    MODE_DOWN    = 2'b01,
    MODE_UPDOWN  = 2'b10,
    MODE_ONESHOT = 2'b11
  } mode_t;

  localparam logic [NUM_CNT_BITS-1:0]  CNT_ZERO = '0;
  localparam logic [NUM_CNT_BITS-1:0]  CNT_ONE  = NUM_CNT_BITS'(1);
  localparam logic [PRESCALE_BITS-1:0] PS_ZERO  = '0;
  localparam logic [PRESCALE_BITS-1:0] PS_ONE   = PRESCALE_BITS'(1);

  // State registers
  logic [PRESCALE_BITS-1:0]        r_pcnt;
  logic [NUM_CNT_BITS-1:0]         r_count;
  logic                            r_dir;
  logic                            r_done;
  logic                            r_rollover;
  logic [NUM_CNT_BITS-1:0]         r_period_sh;
  logic [NUM_CMP*NUM_CNT_BITS-1:0] r_cmp_sh;
  logic [NUM_CMP-1:0]              r_cmp_match;

  // Next-state and control wires
  mode_t                           w_mode;
  logic                            w_run;
  logic                            w_tick;
  logic                            w_update;
  logic                            w_load_sh;
  logic [PRESCALE_BITS-1:0]        w_pcnt_nxt;
  logic [NUM_CNT_BITS-1:0]         w_count_nxt;
  logic [NUM_CNT_BITS-1:0]         w_count_inc;
  logic [NUM_CNT_BITS-1:0]         w_count_dec;
  logic                            w_dir_nxt;
  logic                            w_done_nxt;
  logic [NUM_CNT_BITS-1:0]         w_period_sh_nxt;
  logic [NUM_CMP*NUM_CNT_BITS-1:0] w_cmp_sh_nxt;
  logic [NUM_CMP-1:0]              w_cmp_match_nxt;

  assign w_mode      = mode_t'(i_mode);
  assign w_count_inc = r_count + CNT_ONE;
  assign w_count_dec = r_count - CNT_ONE;

  // A finished one-shot freezes the prescaler as well as the counter, so the
  // timer is completely idle until a clear arrives.
  assign w_run  = i_count_enable && !r_done;
  assign w_tick = w_run && (r_pcnt == i_prescale);

  // Prescaler: divides enabled cycles by i_prescale+1 and holds its value
  // whenever the timer is not running.
  always_comb begin
    w_pcnt_nxt = r_pcnt;
    if (i_clear) begin
      w_pcnt_nxt = PS_ZERO;
    end else if (w_tick) begin
      w_pcnt_nxt = PS_ZERO;
    end else if (w_run) begin
      w_pcnt_nxt = r_pcnt + PS_ONE;
    end
  end

  // Counter core. All arithmetic uses the period shadow so a new period only
  // applies from the next boundary. A zero period pins the count at 0 and
  // makes every tick an update event in all modes.
  //
  // In up-down mode the direction flag flips in the same cycle the count
  // reaches a turning point: it reads 1 while the count sits at P and 0
  // again when the count lands on 0, which is also where the update event
  // (the valley) is placed. This keeps dir aligned with the slope the PWM
  // stage sees at each visible count.
  always_comb begin
    w_count_nxt = r_count;
    w_dir_nxt   = r_dir;
    w_done_nxt  = r_done;
    w_update    = 1'b0;
    if (i_clear) begin
      w_count_nxt = CNT_ZERO;
      w_dir_nxt   = 1'b0;
      w_done_nxt  = 1'b0;
    end else if (w_tick) begin
      if (r_period_sh == CNT_ZERO) begin
        w_count_nxt = CNT_ZERO;
        w_dir_nxt   = 1'b0;
        w_update    = 1'b1;
        if (w_mode == MODE_ONESHOT) begin
          w_done_nxt = 1'b1;
        end
      end else begin
        case (w_mode)
          MODE_UP: begin
            if (r_count >= r_period_sh) begin
              w_count_nxt = CNT_ZERO;
              w_update    = 1'b1;
            end else begin
              w_count_nxt = w_count_inc;
            end
          end
          MODE_DOWN: begin
            if (r_count == CNT_ZERO) begin
              w_count_nxt = r_period_sh;
              w_update    = 1'b1;
            end else begin
              w_count_nxt = w_count_dec;
            end
          end
          MODE_UPDOWN: begin
            if (!r_dir) begin
              if (r_count >= r_period_sh) begin
                w_count_nxt = r_period_sh - CNT_ONE;
                w_dir_nxt   = 1'b1;
              end else begin
                w_count_nxt = w_count_inc;
                w_dir_nxt   = (w_count_inc >= r_period_sh);
              end
            end else begin
              if (r_count <= CNT_ONE) begin
                w_count_nxt = CNT_ZERO;
                w_dir_nxt   = 1'b0;
                w_update    = 1'b1;
              end else begin
                w_count_nxt = w_count_dec;
              end
            end
          end
          default: begin
            if (r_count >= r_period_sh) begin
              w_count_nxt = CNT_ZERO;
              w_done_nxt  = 1'b1;
              w_update    = 1'b1;
            end else begin
              w_count_nxt = w_count_inc;
            end
          end
        endcase
      end
    end
    if (w_mode != MODE_UPDOWN) begin
      w_dir_nxt = 1'b0;
    end
  end

  // Shadow registers reload from the live inputs on clear and on every
  // update event; otherwise mid-period writes are ignored.
  assign w_load_sh = i_clear || w_update;

  always_comb begin
    w_period_sh_nxt = r_period_sh;
    w_cmp_sh_nxt    = r_cmp_sh;
    if (w_load_sh) begin
      w_period_sh_nxt = i_period;
      w_cmp_sh_nxt    = i_cmp_val;
    end
  end

  // Compare outputs are registered but built from the next count and the
  // next shadows, so they line up with o_count_out in the same cycle.
  always_comb begin
    w_cmp_match_nxt = '0;
    for (int i = 0; i < NUM_CMP; i++) begin
      w_cmp_match_nxt[i] = (w_count_nxt < w_cmp_sh_nxt[i*NUM_CNT_BITS +: NUM_CNT_BITS]);
    end
  end

  // State update with asynchronous active-low reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pcnt      <= PS_ZERO;
      r_count     <= CNT_ZERO;
      r_dir       <= 1'b0;
      r_done      <= 1'b0;
      r_rollover  <= 1'b0;
      r_period_sh <= CNT_ZERO;
      r_cmp_sh    <= '0;
      r_cmp_match <= '0;
    end else begin
      r_pcnt      <= w_pcnt_nxt;
      r_count     <= w_count_nxt;
      r_dir       <= w_dir_nxt;
      r_done      <= w_done_nxt;
      r_rollover  <= w_update;
      r_period_sh <= w_period_sh_nxt;
      r_cmp_sh    <= w_cmp_sh_nxt;
      r_cmp_match <= w_cmp_match_nxt;
    end
  end

  assign o_count_out     = r_count;
  assign o_dir           = r_dir;
  assign o_rollover_flag = r_rollover;
  assign o_cmp_match     = r_cmp_match;
  assign o_done          = r_done;

endmodule

// File: tb/tb_flex_timer.sv
// ---------------------------------------------------------------------------
// tb_flex_timer
//   Self-checking bench for flex_timer. A behavioural model derives the count
//   from the number of ticks since the last clear using closed-form period
//   arithmetic; a compare process checks every output against it on each
//   falling edge. Directed sequences add hand-computed literal expectations.
// ---------------------------------------------------------------------------
module tb_flex_timer;

  localparam int N  = 8;
  localparam int NC = 2;
  localparam int PB = 4;

  logic          clk = 1'b0;
  logic          rstN = 1'b1;
  logic          clear;
  logic          countEnable;
  logic [1:0]    mode;
  logic [N-1:0]  period;
  logic [PB-1:0] prescale;
  logic [NC*N-1:0] cmpVal;
  logic [N-1:0]  countOut;
  logic          dir;
  logic          rollover;
  logic [NC-1:0] cmpMatch;
  logic          done;

  int total = 0;
  int bad   = 0;

  // Model state
  int mEn, mT, mP, mMode, mCount, mDir, mDone, mRoll, mTick, mUpd;
  int mCmpSh [NC];

  flex_timer #(.NUM_CNT_BITS(N), .NUM_CMP(NC), .PRESCALE_BITS(PB)) dut (
    .i_clk           (clk),
    .i_rst_n         (rstN),
    .i_clear         (clear),
    .i_count_enable  (countEnable),
    .i_mode          (mode),
    .i_period        (period),
    .i_prescale      (prescale),
    .i_cmp_val       (cmpVal),
    .o_count_out     (countOut),
    .o_dir           (dir),
    .o_rollover_flag (rollover),
    .o_cmp_match     (cmpMatch),
    .o_done          (done)
  );

  always #5 clk = ~clk;

  // Records one comparison and reports it if it does not hold.
  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Drives all inputs just after a falling edge.
  task automatic applyStimulus(input logic clr, input logic en, input logic [1:0] md,
                               input int per, input int ps, input int c0, input int c1);
    logic [N-1:0] v0;
    logic [N-1:0] v1;
    @(negedge clk);
    v0 = N'(c0);
    v1 = N'(c1);
    clear       = clr;
    countEnable = en;
    mode        = md;
    period      = N'(per);
    prescale    = PB'(ps);
    cmpVal      = {v1, v0};
  endtask

  task automatic tickOnce();
    @(posedge clk);
    #1;
  endtask

  // State of the timer after t ticks since clear, for terminal value p.
  // upd tells whether the tick that produced this state was an update event.
  function automatic void modelAt(input int md, input int p, input int t,
                                  output int cnt, output int dr, output int dn, output int upd);
    int phase;
    cnt = 0; dr = 0; dn = 0; upd = 0;
    case (md)
      0: begin
        cnt = t % (p + 1);
        upd = (cnt == 0);
      end
      1: begin
        cnt = (p + 1 - (t % (p + 1))) % (p + 1);
        upd = (cnt == p);
      end
      2: begin
        if (p == 0) begin
          upd = 1;
        end else begin
          phase = t % (2 * p);
          cnt   = (phase <= p) ? phase : 2 * p - phase;
          dr    = (phase >= p);
          upd   = (phase == 0);
        end
      end
      default: begin
        if (t <= p) begin
          cnt = t;
        end else begin
          dn  = 1;
          upd = 1;
        end
      end
    endcase
  endfunction

  // Behavioural model: counts enabled cycles and ticks since the last clear.
  always @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      mEn = 0; mT = 0; mP = 0; mMode = 0;
      mCount = 0; mDir = 0; mDone = 0; mRoll = 0;
      for (int i = 0; i < NC; i++) mCmpSh[i] = 0;
    end else if (clear) begin
      mEn = 0; mT = 0; mP = int'(period); mMode = int'(mode);
      mCount = 0; mDir = 0; mDone = 0; mRoll = 0;
      for (int i = 0; i < NC; i++) mCmpSh[i] = int'(cmpVal[i*N +: N]);
    end else begin
      mRoll = 0;
      if (countEnable && (mDone == 0)) begin
        mTick = ((mEn % (int'(prescale) + 1)) == int'(prescale)) ? 1 : 0;
        mEn++;
        if (mTick != 0) begin
          mT++;
          modelAt(mMode, mP, mT, mCount, mDir, mDone, mUpd);
          if (mUpd != 0) begin
            mRoll = 1;
            for (int i = 0; i < NC; i++) mCmpSh[i] = int'(cmpVal[i*N +: N]);
          end
        end
      end
    end
  end

  // Compare process: every falling edge, all outputs against the model.
  always @(negedge clk) begin
    checkOutput("model_count", int'(countOut), mCount);
    checkOutput("model_dir", int'(dir), mDir);
    checkOutput("model_rollover", int'(rollover), mRoll);
    checkOutput("model_done", int'(done), mDone);
    for (int i = 0; i < NC; i++) begin
      checkOutput($sformatf("model_cmp%0d", i), int'(cmpMatch[i]), (mCount < mCmpSh[i]) ? 1 : 0);
    end
  end

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    bad++;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int t1Cnt [7]  = '{0, 1, 2, 3, 4, 0, 1};
    int t1Roll [7] = '{0, 0, 0, 0, 0, 1, 0};
    int t3Cnt [8]  = '{0, 1, 2, 3, 2, 1, 0, 1};
    int t3Dir [8]  = '{0, 0, 0, 1, 1, 1, 0, 0};
    int t3Roll [8] = '{0, 0, 0, 0, 0, 0, 1, 0};
    int ones0, ones1, rolls;

    clear = 1'b0; countEnable = 1'b0; mode = 2'b00;
    period = '0; prescale = '0; cmpVal = '0;
    #1 rstN = 1'b0;
    #11;
    checkOutput("reset_count", int'(countOut), 0);
    checkOutput("reset_match", int'(cmpMatch), 0);
    checkOutput("reset_done", int'(done), 0);
    @(negedge clk);
    rstN = 1'b1;

    // T1: up, P=4, no prescale
    $display("[TB] T1 up counting");
    applyStimulus(1, 0, 2'b00, 4, 0, 0, 0);
    tickOnce();
    checkOutput("t1_count0", int'(countOut), t1Cnt[0]);
    applyStimulus(0, 1, 2'b00, 4, 0, 0, 0);
    for (int k = 1; k < 7; k++) begin
      tickOnce();
      checkOutput("t1_count", int'(countOut), t1Cnt[k]);
      checkOutput("t1_roll", int'(rollover), t1Roll[k]);
    end

    // T2: prescale 2 with an enable gap in mid-value
    $display("[TB] T2 prescaler and enable gap");
    applyStimulus(1, 0, 2'b00, 5, 2, 0, 0);
    tickOnce();
    applyStimulus(0, 1, 2'b00, 5, 2, 0, 0);
    tickOnce(); tickOnce();
    checkOutput("t2_held", int'(countOut), 0);
    tickOnce();
    checkOutput("t2_first", int'(countOut), 1);
    tickOnce(); tickOnce(); tickOnce();
    checkOutput("t2_second", int'(countOut), 2);
    tickOnce();
    applyStimulus(0, 0, 2'b00, 5, 2, 0, 0);
    for (int k = 0; k < 5; k++) begin
      tickOnce();
      checkOutput("t2_frozen", int'(countOut), 2);
    end
    applyStimulus(0, 1, 2'b00, 5, 2, 0, 0);
    tickOnce();
    checkOutput("t2_resume_hold", int'(countOut), 2);
    tickOnce();
    checkOutput("t2_resume_step", int'(countOut), 3);

    // T3: up-down, P=3
    $display("[TB] T3 up-down");
    applyStimulus(1, 0, 2'b10, 3, 0, 0, 0);
    tickOnce();
    checkOutput("t3_count0", int'(countOut), t3Cnt[0]);
    checkOutput("t3_dir0", int'(dir), t3Dir[0]);
    applyStimulus(0, 1, 2'b10, 3, 0, 0, 0);
    for (int k = 1; k < 8; k++) begin
      tickOnce();
      checkOutput("t3_count", int'(countOut), t3Cnt[k]);
      checkOutput("t3_dir", int'(dir), t3Dir[k]);
      checkOutput("t3_roll", int'(rollover), t3Roll[k]);
    end

    // Down: first tick after clear goes 0 -> P with a rollover pulse
    $display("[TB] down counting");
    applyStimulus(1, 0, 2'b01, 3, 0, 0, 0);
    tickOnce();
    applyStimulus(0, 1, 2'b01, 3, 0, 0, 0);
    tickOnce();
    checkOutput("down_reload", int'(countOut), 3);
    checkOutput("down_roll", int'(rollover), 1);
    tickOnce();
    checkOutput("down_step", int'(countOut), 2);

    // T4: compare channels and shadowed compare writes
    $display("[TB] T4 compare");
    applyStimulus(1, 0, 2'b00, 9, 0, 3, 0);
    tickOnce();
    ones0 = int'(cmpMatch[0]);
    ones1 = int'(cmpMatch[1]);
    applyStimulus(0, 1, 2'b00, 9, 0, 3, 0);
    for (int k = 1; k < 10; k++) begin
      tickOnce();
      ones0 += int'(cmpMatch[0]);
      ones1 += int'(cmpMatch[1]);
    end
    checkOutput("t4_ones_ch0", ones0, 3);
    checkOutput("t4_ones_ch1", ones1, 0);
    for (int k = 0; k < 6; k++) tickOnce();
    checkOutput("t4_at5", int'(countOut), 5);
    applyStimulus(0, 1, 2'b00, 9, 0, 7, 0);
    tickOnce();
    checkOutput("t4_old_sh6", int'(cmpMatch[0]), 0);
    tickOnce(); tickOnce();
    checkOutput("t4_old_sh8", int'(cmpMatch[0]), 0);
    tickOnce(); tickOnce();
    checkOutput("t4_wrap_count", int'(countOut), 0);
    checkOutput("t4_new_sh0", int'(cmpMatch[0]), 1);
    for (int k = 0; k < 6; k++) tickOnce();
    checkOutput("t4_new_sh6", int'(cmpMatch[0]), 1);
    tickOnce();
    checkOutput("t4_new_sh7", int'(cmpMatch[0]), 0);
    applyStimulus(1, 0, 2'b00, 9, 0, 7, 12);
    tickOnce();
    ones0 = int'(cmpMatch[0]);
    ones1 = int'(cmpMatch[1]);
    applyStimulus(0, 1, 2'b00, 9, 0, 7, 12);
    for (int k = 1; k < 10; k++) begin
      tickOnce();
      ones0 += int'(cmpMatch[0]);
      ones1 += int'(cmpMatch[1]);
    end
    checkOutput("t4_ones7_ch0", ones0, 7);
    checkOutput("t4_ones12_ch1", ones1, 10);

    // T5: one-shot, P=2
    $display("[TB] T5 one-shot");
    applyStimulus(1, 0, 2'b11, 2, 0, 0, 0);
    tickOnce();
    applyStimulus(0, 1, 2'b11, 2, 0, 0, 0);
    rolls = 0;
    tickOnce(); rolls += int'(rollover);
    checkOutput("t5_c1", int'(countOut), 1);
    tickOnce(); rolls += int'(rollover);
    checkOutput("t5_c2", int'(countOut), 2);
    tickOnce(); rolls += int'(rollover);
    checkOutput("t5_end", int'(countOut), 0);
    checkOutput("t5_done", int'(done), 1);
    for (int k = 0; k < 5; k++) begin
      tickOnce(); rolls += int'(rollover);
      checkOutput("t5_hold", int'(countOut), 0);
    end
    checkOutput("t5_rolls", rolls, 1);
    checkOutput("t5_done_held", int'(done), 1);
    applyStimulus(1, 1, 2'b11, 2, 0, 0, 0);
    tickOnce();
    checkOutput("t5_clr_done", int'(done), 0);
    applyStimulus(0, 1, 2'b11, 2, 0, 0, 0);
    tickOnce();
    checkOutput("t5_restart", int'(countOut), 1);

    // T6: clear beats enable, then asynchronous reset mid-count
    $display("[TB] T6 clear priority and async reset");
    applyStimulus(1, 0, 2'b00, 9, 0, 4, 12);
    tickOnce();
    applyStimulus(0, 1, 2'b00, 9, 0, 4, 12);
    for (int k = 0; k < 6; k++) tickOnce();
    checkOutput("t6_at6", int'(countOut), 6);
    applyStimulus(1, 1, 2'b00, 9, 0, 4, 12);
    tickOnce();
    checkOutput("t6_clear_prio", int'(countOut), 0);
    applyStimulus(0, 1, 2'b00, 9, 0, 4, 12);
    tickOnce(); tickOnce(); tickOnce();
    checkOutput("t6_at3", int'(countOut), 3);
    checkOutput("t6_match_before", int'(cmpMatch), 3);
    #2 rstN = 1'b0;
    #1;
    checkOutput("t6_rst_count", int'(countOut), 0);
    checkOutput("t6_rst_match", int'(cmpMatch), 0);
    checkOutput("t6_rst_roll", int'(rollover), 0);
    checkOutput("t6_rst_dir", int'(dir), 0);
    checkOutput("t6_rst_done", int'(done), 0);
    applyStimulus(0, 0, 2'b00, 9, 0, 4, 12);
    rstN = 1'b1;
    tickOnce(); tickOnce();

    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
